// File: rtl/sequence_checker.sv
// Receive-side lock/error checker for the repeating word sequence 6,9,11,15,10,8,2,5.
// Optional sticky error flag with clear input when SEQ_CHK_STICKY_EN is defined.
//
// state   | meaning
// HUNT    | searching for any sequence member to start a candidate run
// CONFIRM | counting consecutive in-sequence words toward lock
// LOCKED  | tracking sequence; mismatches pulse err and count toward loss
module sequence_checker #(
  parameter int LOCK_LEN  = 3,
  parameter int LOSS_LEN  = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [3:0]           din,
  output logic                 locked,
  output logic                 err,
  output logic [3:0]           expected,
  output logic [ERR_CNT_W-1:0] err_cnt
`ifdef SEQ_CHK_STICKY_EN
  ,
  input  logic                 err_clr,
  output logic                 err_sticky
`endif
);

  typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_t;

  state_t               state, nxt_state;
  logic [3:0]           run, nxt_run;
  logic [3:0]           miss, nxt_miss;
  logic [3:0]           nxt_expected;
  logic                 nxt_err;
  logic [ERR_CNT_W-1:0] nxt_err_cnt;

  function automatic logic [3:0] nxt(input logic [3:0] v);
    case (v)
      4'd6:    nxt = 4'd9;
      4'd9:    nxt = 4'd11;
      4'd11:   nxt = 4'd15;
      4'd15:   nxt = 4'd10;
      4'd10:   nxt = 4'd8;
      4'd8:    nxt = 4'd2;
      4'd2:    nxt = 4'd5;
      4'd5:    nxt = 4'd6;
      default: nxt = 4'd0;
    endcase
  endfunction

  function automatic logic is_member(input logic [3:0] v);
    case (v)
      4'd2, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11, 4'd15: is_member = 1'b1;
      default:                                          is_member = 1'b0;
    endcase
  endfunction

  always_comb begin
    nxt_state    = state;
    nxt_run      = run;
    nxt_miss     = miss;
    nxt_expected = expected;
    nxt_err      = 1'b0;
    nxt_err_cnt  = err_cnt;
    if (en) begin
      case (state)
        HUNT: begin
          if (is_member(din)) begin
            nxt_expected = nxt(din);
            nxt_run      = 4'd1;
            if (LOCK_LEN == 1) begin
              nxt_state = LOCKED;
              nxt_miss  = 4'd0;
            end else begin
              nxt_state = CONFIRM;
            end
          end
        end
        CONFIRM: begin
          if (din == expected) begin
            nxt_run      = run + 4'd1;
            nxt_expected = nxt(din);
            if (run + 4'd1 == 4'(LOCK_LEN)) begin
              nxt_state = LOCKED;
              nxt_miss  = 4'd0;
            end
          end else if (is_member(din)) begin
            nxt_run      = 4'd1;
            nxt_expected = nxt(din);
          end else begin
            nxt_state = HUNT;
            nxt_run   = 4'd0;
          end
        end
        LOCKED: begin
          // free-run over corrupted words so a single bad word does not desync
          nxt_expected = nxt(expected);
          if (din == expected) begin
            nxt_miss = 4'd0;
          end else begin
            nxt_err  = 1'b1;
            nxt_miss = miss + 4'd1;
            if (err_cnt != {ERR_CNT_W{1'b1}})
              nxt_err_cnt = err_cnt + ERR_CNT_W'(1);
            if (miss + 4'd1 == 4'(LOSS_LEN)) begin
              nxt_state = HUNT;
              nxt_run   = 4'd0;
            end
          end
        end
        default: nxt_state = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= HUNT;
      run      <= 4'd0;
      miss     <= 4'd0;
      expected <= 4'd6;
      err      <= 1'b0;
      err_cnt  <= '0;
      locked   <= 1'b0;
    end else begin
      state    <= nxt_state;
      run      <= nxt_run;
      miss     <= nxt_miss;
      expected <= nxt_expected;
      err      <= nxt_err;
      err_cnt  <= nxt_err_cnt;
      locked   <= (nxt_state == LOCKED);
    end
  end

`ifdef SEQ_CHK_STICKY_EN
  // a new mismatch on the clearing edge keeps the flag set
  always_ff @(posedge clk) begin
    if (!rst_n)
      err_sticky <= 1'b0;
    else if (nxt_err)
      err_sticky <= 1'b1;
    else if (err_clr)
      err_sticky <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_sequence_checker.sv
// Scoreboard bench for sequence_checker: driver pushes expected outputs per edge,
// monitor pops and compares just after each clock edge.
module tb_sequence_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] din = 4'd0;
  logic       locked, err;
  logic [3:0] expected;
  logic [1:0] err_cnt;
`ifdef SEQ_CHK_STICKY_EN
  logic       err_clr = 1'b0;
  logic       err_sticky;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       locked;
    logic       err;
    logic [3:0] expected;
    logic [1:0] cnt;
    string      tag;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  sequence_checker #(.LOCK_LEN(3), .LOSS_LEN(2), .ERR_CNT_W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .din      (din),
    .locked   (locked),
    .err      (err),
    .expected (expected),
    .err_cnt  (err_cnt)
`ifdef SEQ_CHK_STICKY_EN
    ,
    .err_clr    (err_clr),
    .err_sticky (err_sticky)
`endif
  );

  task automatic step(input logic r, input logic e, input logic [3:0] d,
                      input logic xl, input logic xe, input logic [3:0] xx,
                      input logic [1:0] xc, input string tag);
    exp_t x;
    @(negedge clk);
    rst_n = r;
    en    = e;
    din   = d;
    x.locked = xl; x.err = xe; x.expected = xx; x.cnt = xc; x.tag = tag;
    q.push_back(x);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        #1;
        chk({x.tag, ".locked"},   {3'b0, locked},  {3'b0, x.locked});
        chk({x.tag, ".err"},      {3'b0, err},     {3'b0, x.err});
        chk({x.tag, ".expected"}, expected,        x.expected);
        chk({x.tag, ".err_cnt"},  {2'b0, err_cnt}, {2'b0, x.cnt});
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [3:0] nm [8];
    nm = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd7, 4'd12, 4'd13, 4'd14};

    step(0, 0, 0, 0, 0, 6, 0, "reset");
    // lock on 6,9,11
    step(1, 1, 6,  0, 0, 9,  0, "t1_6");
    step(1, 1, 9,  0, 0, 11, 0, "t1_9");
    step(1, 1, 11, 1, 0, 15, 0, "t1_11");
    // single corrupted word
    step(1, 1, 15, 1, 0, 10, 0, "t2_15");
    step(1, 1, 7,  1, 1, 8,  1, "t2_bad7");
    step(1, 1, 8,  1, 0, 2,  1, "t2_8");
    step(1, 1, 2,  1, 0, 5,  1, "t2_2");
    // two consecutive bad words drop lock, then relock
    step(1, 1, 0,  1, 1, 6,  2, "t3_bad0a");
    step(1, 1, 0,  0, 1, 9,  3, "t3_bad0b");
    step(1, 1, 6,  0, 0, 9,  3, "t3_6");
    step(1, 1, 9,  0, 0, 11, 3, "t3_9");
    step(1, 1, 11, 1, 0, 15, 3, "t3_11");
    // en gating while locked
    step(1, 1, 15, 1, 0, 10, 3, "t5_15");
    step(1, 0, 0,  1, 0, 10, 3, "t5_hold_a");
    step(1, 1, 10, 1, 0, 8,  3, "t5_10");
    step(1, 0, 7,  1, 0, 8,  3, "t5_hold_b");
    step(1, 1, 8,  1, 0, 2,  3, "t5_8");
    step(1, 1, 2,  1, 0, 5,  3, "t5_2");
    step(1, 0, 1,  1, 0, 5,  3, "t5_hold_c");
    step(1, 1, 5,  1, 0, 6,  3, "t5_5");
    step(1, 1, 6,  1, 0, 9,  3, "t5_6");
    step(1, 0, 3,  1, 0, 9,  3, "t5_hold_d");
    step(1, 1, 9,  1, 0, 11, 3, "t5_9");
    step(1, 1, 1,  1, 1, 15, 3, "t5_sat_bad");
    step(1, 1, 15, 1, 0, 10, 3, "t5_15b");
    // reset while locked, and reset overriding en
    step(0, 1, 10, 0, 0, 6,  0, "t6_rst");
    step(0, 1, 6,  0, 0, 6,  0, "t6_rst_en");
    // non-members only stay in HUNT
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 8; i++)
        step(1, 1, nm[i], 0, 0, 6, 0, "t4_nonmember");
    // confirm restart on member mismatch, drop on non-member
    step(1, 1, 6, 0, 0, 9, 0, "c_6");
    step(1, 1, 2, 0, 0, 5, 0, "c_restart2");
    step(1, 1, 5, 0, 0, 6, 0, "c_5");
    step(1, 1, 0, 0, 0, 6, 0, "c_nonmember");
    step(1, 1, 8, 0, 0, 2, 0, "c_8");
    step(1, 1, 2, 0, 0, 5, 0, "c_2");
    step(1, 1, 5, 1, 0, 6, 0, "c_5_lock");
    // five isolated errors saturate the 2-bit counter at 3
    step(1, 1, 0,  1, 1, 9,  1, "s_bad1");
    step(1, 1, 9,  1, 0, 11, 1, "s_9");
    step(1, 1, 0,  1, 1, 15, 2, "s_bad2");
    step(1, 1, 15, 1, 0, 10, 2, "s_15");
    step(1, 1, 0,  1, 1, 8,  3, "s_bad3");
    step(1, 1, 8,  1, 0, 2,  3, "s_8");
    step(1, 1, 0,  1, 1, 5,  3, "s_bad4");
    step(1, 1, 5,  1, 0, 6,  3, "s_5");
    step(1, 1, 0,  1, 1, 9,  3, "s_bad5");
    step(1, 1, 9,  1, 0, 11, 3, "s_9b");

    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
